// File: rtl/gvt_arbiter.sv
// Global virtual time reducer: periodically scans every tile's LVT, takes the
// minimum and publishes a monotonic GVT, flagging termination and regressions.
module gvt_arbiter #(
  parameter int N_TILES        = 1,
  parameter int TS_WIDTH       = 32,
  parameter int TB_WIDTH       = 32,
  parameter int LOG_GVT_PERIOD = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic [N_TILES-1:0]                    lvt_valid,
  input  logic [N_TILES*(TS_WIDTH+TB_WIDTH)-1:0] lvt,
  output logic [TS_WIDTH+TB_WIDTH-1:0]          gvt,
  output logic                                  gvt_valid,
  output logic                                  done,
  output logic                                  regress
);

  localparam int VT_WIDTH = TS_WIDTH + TB_WIDTH;
  localparam int IDX_W    = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam int N_PAD    = 1 << IDX_W;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_TILES - 1);
  localparam logic [VT_WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

  state_t                    state_q, state_d;
  logic                      start;
  logic [LOG_GVT_PERIOD-1:0] cnt_q;
  logic                      req_q;
  logic                      pending_q;
  logic [IDX_W-1:0]          idx_q;
  logic [VT_WIDTH-1:0]       min_q;
  logic [VT_WIDTH-1:0]       lvt_arr [N_PAD];
  logic [N_PAD-1:0]          valid_pad;
  logic [VT_WIDTH-1:0]       cur_vt;
  logic                      take;

  // Pad to a power of two so the scan index never selects outside the table;
  // padding slots look like invalid, idle tiles.
  for (genvar i = 0; i < N_PAD; i++) begin : g_pad
    if (i < N_TILES) begin : g_tile
      assign lvt_arr[i]   = lvt[i*VT_WIDTH +: VT_WIDTH];
      assign valid_pad[i] = lvt_valid[i];
    end else begin : g_fill
      assign lvt_arr[i]   = ALL_ONES;
      assign valid_pad[i] = 1'b0;
    end
  end

  assign cur_vt = lvt_arr[idx_q];
  assign take   = valid_pad[idx_q] && (cur_vt < min_q);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_q || pending_q) begin
          state_d = SCAN;
          start   = 1'b1;
        end
      end
      SCAN:    if (idx_q == LAST_IDX) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The wrap is registered, so a round request is seen one cycle after the
  // counter reaches all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      req_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      if (enable) cnt_q <= cnt_q + 1'b1;
      req_q <= enable && (&cnt_q);
      if (start)                         pending_q <= 1'b0;
      else if (req_q && state_q != IDLE) pending_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      min_q     <= ALL_ONES;
      gvt       <= '0;
      gvt_valid <= 1'b0;
      done      <= 1'b0;
      regress   <= 1'b0;
    end else begin
      gvt_valid <= (state_q == UPDATE);
      if (start) begin
        idx_q <= '0;
        min_q <= ALL_ONES;
      end else if (state_q == SCAN) begin
        if (take) min_q <= cur_vt;
        idx_q <= idx_q + 1'b1;
      end
      if (state_q == UPDATE) begin
        if (min_q == ALL_ONES) begin
          done <= 1'b1;
          gvt  <= ALL_ONES;
        end else if (min_q >= gvt) begin
          gvt <= min_q;
        end else begin
          regress <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gvt_arbiter.sv
// Directed bench for gvt_arbiter: a P=3 instance for rounds, regression,
// termination and mid-round reset, and a P=1 instance for back-to-back rounds.
module tb_gvt_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable_a, enable_b;
  logic [N-1:0]   lvt_valid;
  logic [N*W-1:0] lvt;
  logic [W-1:0]   gvt_a, gvt_b;
  logic           gvt_valid_a, gvt_valid_b;
  logic           done_a, done_b, regress_a, regress_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gvt_arbiter #(.N_TILES(N), .TS_WIDTH(32), .TB_WIDTH(32), .LOG_GVT_PERIOD(3)) dut_a (
    .clk(clk), .rst(rst), .enable(enable_a), .lvt_valid(lvt_valid), .lvt(lvt),
    .gvt(gvt_a), .gvt_valid(gvt_valid_a), .done(done_a), .regress(regress_a)
  );

  gvt_arbiter #(.N_TILES(N), .TS_WIDTH(32), .TB_WIDTH(32), .LOG_GVT_PERIOD(1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable_b), .lvt_valid(lvt_valid), .lvt(lvt),
    .gvt(gvt_b), .gvt_valid(gvt_valid_b), .done(done_b), .regress(regress_b)
  );

  function automatic logic [W-1:0] vt(input logic [31:0] ts, input logic [31:0] tb);
    return {ts, tb};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_lvt(input logic [W-1:0] t0, input logic [W-1:0] t1,
                         input logic [W-1:0] t2, input logic [W-1:0] t3,
                         input logic [N-1:0] v);
    lvt       = {t3, t2, t1, t0};
    lvt_valid = v;
  endtask

  // Counts rising edges until the selected gvt_valid is seen high, bounded.
  task automatic wait_pulse(input bit sel_b, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(sel_b ? gvt_valid_b : gvt_valid_a) && n < 200);
  endtask

  initial begin
    int n;
    int pulses;
    logic [W-1:0] ones;
    ones = '1;

    rst      = 1'b1;
    enable_a = 1'b1;
    enable_b = 1'b0;
    set_lvt(vt(10, 0), vt(5, 7), vt(9, 1), vt(5, 3), 4'b1111);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_gvt", gvt_a, '0);
    check("reset_valid", W'(gvt_valid_a), '0);
    check("reset_done", W'(done_a), '0);
    check("reset_regress", W'(regress_a), '0);

    // Round 1: minimum decided by the tiebreaker
    wait_pulse(1'b0, n);
    check("t1_latency", W'(n), 64'd14);
    check("t1_gvt", gvt_a, vt(5, 3));

    // Round 2: invalid tile 3 carries a small value that must be ignored
    set_lvt(vt(12, 0), vt(6, 0), vt(20, 0), vt(1, 0), 4'b0111);
    wait_pulse(1'b0, n);
    check("t2_period", W'(n), 64'd8);
    check("t2_gvt", gvt_a, vt(6, 0));

    // Round 3: minimum below current gvt
    set_lvt(vt(4, 0), vt(7, 0), vt(8, 0), vt(9, 0), 4'b1111);
    wait_pulse(1'b0, n);
    check("t3_period", W'(n), 64'd8);
    check("t3_gvt_held", gvt_a, vt(6, 0));
    check("t3_regress", W'(regress_a), 64'd1);
    check("t3_done", W'(done_a), '0);

    // Round 4: all tiles idle
    set_lvt(ones, ones, ones, ones, 4'b1111);
    wait_pulse(1'b0, n);
    check("t4_period", W'(n), 64'd8);
    check("t4_gvt", gvt_a, ones);
    check("t4_done", W'(done_a), 64'd1);

    // Following round: sticky flags, gvt never drops from all-ones
    set_lvt(vt(3, 0), vt(7, 0), vt(8, 0), vt(9, 0), 4'b1111);
    wait_pulse(1'b0, n);
    check("t4b_period", W'(n), 64'd8);
    check("t4b_gvt", gvt_a, ones);
    check("t4b_done", W'(done_a), 64'd1);
    check("t4b_regress", W'(regress_a), 64'd1);

    // Reset during the next round's scan
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_gvt", gvt_a, '0);
    check("t6_done", W'(done_a), '0);
    check("t6_regress", W'(regress_a), '0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (gvt_valid_a) pulses++;
    end
    check("t6_no_pulse", W'(pulses), '0);
    set_lvt(vt(7, 1), vt(7, 2), vt(8, 0), vt(9, 0), 4'b1111);
    rst = 1'b0;
    wait_pulse(1'b0, n);
    check("t6_latency", W'(n), 64'd14);
    check("t6_gvt", gvt_a, vt(7, 1));

    // Back-to-back rounds on the short-period instance
    enable_a = 1'b0;
    set_lvt(vt(2, 0), vt(3, 0), vt(4, 0), vt(5, 0), 4'b1111);
    enable_b = 1'b1;
    wait_pulse(1'b1, n);
    check("t5_first", W'(n), 64'd8);
    for (int k = 0; k < 3; k++) begin
      wait_pulse(1'b1, n);
      check("t5_interval", W'(n), 64'd6);
    end
    check("t5_gvt", gvt_b, vt(2, 0));
    check("t5_done", W'(done_b), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
